sync_fifo_fwft: RTL and testbench
=================================

SYNC_FIFO_FWFT -- requirements
Module: sync_fifo_fwft

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the data word width in bits.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8, giving the number of entries; it is a power of 2 and at least 2.
REQ-003 The block SHALL have parameter ALMOST_WR, default 2, the almost_full margin; legal range 1..FIFO_DEPTH-1.
REQ-004 The block SHALL have parameter ALMOST_RD, default 1, the almost_empty threshold; legal range 0..FIFO_DEPTH-1.
REQ-005 The block SHALL have parameter FWFT, default 0, selecting read mode: 0 = standard, 1 = first-word-fall-through.
REQ-006 In this section, AW SHALL denote log2(FIFO_DEPTH).
REQ-007 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-008 Port clk SHALL be an input, 1 bit wide, and is the single clock; all state is rising-edge.
REQ-009 Port rst_n SHALL be an input, 1 bit wide, and is the asynchronous active-low reset.
REQ-010 Port clr SHALL be an input, 1 bit wide, and is a synchronous flush.
REQ-011 Port write SHALL be an input, 1 bit wide, and is the write request.
REQ-012 Port wdata SHALL be an input, DATA_WIDTH bits wide, and carries the write data.
REQ-013 Port read SHALL be an input, 1 bit wide, and is the read request (the acknowledge when FWFT=1).
REQ-014 Port rdata SHALL be an output, DATA_WIDTH bits wide, and carries the read data.
REQ-015 Ports full, empty, almost_full and almost_empty SHALL each be a 1-bit output status flag.
REQ-016 Port count SHALL be an output, AW+1 bits wide, giving the current occupancy, 0..FIFO_DEPTH.
REQ-017 Ports wr_err and rd_err SHALL each be a 1-bit output that pulses for one cycle on overflow or underflow respectively.

Function
REQ-018 Storage SHALL be FIFO_DEPTH words; write and read pointers SHALL each be AW+1 bits and wrap modulo 2*FIFO_DEPTH.
REQ-019 A write SHALL be accepted iff write=1, full=0 and clr=0; an accepted write stores wdata at wr_ptr and then increments wr_ptr.
REQ-020 A read SHALL be accepted iff read=1, empty=0 and clr=0; an accepted read increments rd_ptr.
REQ-021 With write and read both accepted in the same cycle, count SHALL be unchanged and order SHALL be preserved.
REQ-022 When full=1, a write SHALL be rejected even if a read is accepted in the same cycle.
REQ-023 count SHALL be a register: count + accepted_write - accepted_read.
REQ-024 Flags SHALL be registered from the next count, so they update in the same cycle as count.
REQ-025 Flag definitions SHALL be: full = (count==FIFO_DEPTH); empty = (count==0).
REQ-026 Flag definitions SHALL be: almost_full = (count >= FIFO_DEPTH-ALMOST_WR); almost_empty = (count <= ALMOST_RD).
REQ-027 With FWFT=0, rdata SHALL be registered: one cycle after an accepted read it shows the head word, and it holds otherwise.
REQ-028 With FWFT=1, rdata SHALL equal mem[rd_ptr] continuously and is valid whenever empty=0.
REQ-029 With FWFT=1, a write into an empty FIFO SHALL be visible on rdata, with empty=0, in the cycle after that write.
REQ-030 With FWFT=1, read SHALL consume the displayed word; the next word SHALL appear the following cycle.
REQ-031 With FWFT=1 and empty=1, rdata SHALL be don't-care.
REQ-032 wr_err SHALL be 1 for exactly the cycle after write=1 while full=1 and clr=0; otherwise it SHALL be 0.
REQ-033 rd_err SHALL be 1 for exactly the cycle after read=1 while empty=1 and clr=0; otherwise it SHALL be 0.
REQ-034 clr SHALL take priority over write and read: next cycle both pointers=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, no error pulses.
REQ-035 clr SHALL leave memory contents untouched; with FWFT=0, clr SHALL clear rdata to 0.

Reset
REQ-036 Assertion of rst_n=0 SHALL act immediately, independent of clk, and may occur mid-operation.
REQ-037 During reset the block SHALL hold: pointers=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, rdata=0, wr_err=0, rd_err=0.
REQ-038 Memory SHALL NOT be reset.
REQ-039 After rst_n deasserts, the first accepted operation SHALL be on the first rising clk edge with rst_n=1.

Verification (defaults, FWFT=0 unless stated)
REQ-040 Ten consecutive writes of 17, 20, 800..807 (8-bit truncated) SHALL give: almost_full=1 at count=6; full=1 at count=8; wr_err pulses on writes 9 and 10; count stays 8.
REQ-041 Fourteen reads after REQ-040 SHALL return rdata 17, 20, 32, 33, 34, 35, 36, 37; empty=1 after the 8th read; almost_empty=1 at count<=1; six rd_err pulses.
REQ-042 With count=4, simultaneous write+read for 3 cycles SHALL keep count=4 and FIFO order. With count=8, write+read SHALL give count=7 and the write SHALL be rejected with a wr_err pulse.
REQ-043 With FWFT=1, a single write of 1 into an empty FIFO SHALL give empty=0 and rdata=1 next cycle with no read. Writing 2, then read, SHALL give rdata=2 next cycle; a second read SHALL give empty=1.
REQ-044 Twenty alternating write/read pairs with data 1..20 SHALL wrap the pointers and return 1..20 in order.
REQ-045 clr asserted with write=1 at count=5 SHALL give count=0 and empty=1 next cycle, with no wr_err.
REQ-046 rst_n pulsed low between clock edges at count=3 SHALL force the REQ-037 values immediately.

Source files
------------

// File: rtl/sync_fifo_fwft.sv
// Synchronous single-clock FIFO with registered status flags and a selectable
// read mode: registered read data (FWFT=0) or first-word-fall-through (FWFT=1).
module sync_fifo_fwft #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int ALMOST_WR  = 2,
  parameter int ALMOST_RD  = 1,
  parameter int FWFT       = 0,
  localparam int AW        = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  read,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [AW:0]           count,
  output logic                  wr_err,
  output logic                  rd_err
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] AF_C    = (AW+1)'(FIFO_DEPTH - ALMOST_WR);
  localparam logic [AW:0] AE_C    = (AW+1)'(ALMOST_RD);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic        full_q, full_d;
  logic        empty_q, empty_d;
  logic        af_q, af_d;
  logic        ae_q, ae_d;
  logic        wr_err_q, wr_err_d;
  logic        rd_err_q, rd_err_d;
  logic        wr_acc_s;
  logic        rd_acc_s;

  // Acceptance uses the registered flags, so a full FIFO rejects a write even
  // when a read frees a slot in the same cycle.
  assign wr_acc_s = write & ~full_q  & ~clr;
  assign rd_acc_s = read  & ~empty_q & ~clr;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    wr_err_d = 1'b0;
    rd_err_d = 1'b0;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_acc_s};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_acc_s};
      wr_err_d = write & full_q;
      rd_err_d = read  & empty_q;
      case ({wr_acc_s, rd_acc_s})
        2'b10:   count_d = count_q + {{AW{1'b0}}, 1'b1};
        2'b01:   count_d = count_q - {{AW{1'b0}}, 1'b1};
        default: count_d = count_q;
      endcase
    end
  end

  // Flags derive from the next count so they move in the same cycle as count.
  always_comb begin
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
    af_d    = (count_d >= AF_C);
    ae_d    = (count_d <= AE_C);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      wr_err_q <= wr_err_d;
      rd_err_q <= rd_err_d;
    end
  end

  // Storage is deliberately left out of reset and flush.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rdata = mem_q[rd_ptr_q[AW-1:0]];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

      always_comb begin
        rdata_d = rdata_q;
        if (clr) begin
          rdata_d = '0;
        end else if (rd_acc_s) begin
          rdata_d = mem_q[rd_ptr_q[AW-1:0]];
        end else begin
          rdata_d = rdata_q;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rdata_q <= '0;
        end else begin
          rdata_q <= rdata_d;
        end
      end

      assign rdata = rdata_q;
    end
  endgenerate

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign wr_err       = wr_err_q;
  assign rd_err       = rd_err_q;

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Scoreboard bench: one standard-mode and one FWFT instance driven with directed
// vectors; read data is checked by monitors popping expected-value queues.
module tb_sync_fifo_fwft;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;

  logic       clr0 = 1'b0, write0 = 1'b0, read0 = 1'b0;
  logic [7:0] wdata0 = 8'd0;
  logic [7:0] rdata0;
  logic       full0, empty0, af0, ae0, wr_err0, rd_err0;
  logic [3:0] count0;

  logic       clr1 = 1'b0, write1 = 1'b0, read1 = 1'b0;
  logic [7:0] wdata1 = 8'd0;
  logic [7:0] rdata1;
  logic       full1, empty1, af1, ae1, wr_err1, rd_err1;
  logic [3:0] count1;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic       pend0 = 1'b0;

  sync_fifo_fwft #(.DATA_WIDTH(8), .FIFO_DEPTH(8), .ALMOST_WR(2), .ALMOST_RD(1), .FWFT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr0), .write(write0), .wdata(wdata0), .read(read0),
    .rdata(rdata0), .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .count(count0), .wr_err(wr_err0), .rd_err(rd_err0));

  sync_fifo_fwft #(.DATA_WIDTH(8), .FIFO_DEPTH(8), .ALMOST_WR(2), .ALMOST_RD(1), .FWFT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr1), .write(write1), .wdata(wdata1), .read(read1),
    .rdata(rdata1), .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .count(count1), .wr_err(wr_err1), .rd_err(rd_err1));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic st0(input string tag, input int cnt, input logic we, input logic re);
    chk({tag, " count0"}, 32'(count0), 32'(cnt));
    chk({tag, " full0"}, 32'(full0), 32'(cnt == 8));
    chk({tag, " empty0"}, 32'(empty0), 32'(cnt == 0));
    chk({tag, " afull0"}, 32'(af0), 32'(cnt >= 6));
    chk({tag, " aempty0"}, 32'(ae0), 32'(cnt <= 1));
    chk({tag, " wr_err0"}, 32'(wr_err0), 32'(we));
    chk({tag, " rd_err0"}, 32'(rd_err0), 32'(re));
  endtask

  task automatic st1(input string tag, input int cnt, input logic we, input logic re);
    chk({tag, " count1"}, 32'(count1), 32'(cnt));
    chk({tag, " full1"}, 32'(full1), 32'(cnt == 8));
    chk({tag, " empty1"}, 32'(empty1), 32'(cnt == 0));
    chk({tag, " wr_err1"}, 32'(wr_err1), 32'(we));
    chk({tag, " rd_err1"}, 32'(rd_err1), 32'(re));
  endtask

  // Inputs change 2 time units after a rising edge; returns 2 units after the next one.
  task automatic cyc0(input logic w, input logic [7:0] wd, input logic r, input logic c);
    write0 = w; wdata0 = wd; read0 = r; clr0 = c;
    @(posedge clk); #2;
    write0 = 1'b0; read0 = 1'b0; clr0 = 1'b0;
  endtask

  task automatic cyc1(input logic w, input logic [7:0] wd, input logic r, input logic c);
    write1 = w; wdata1 = wd; read1 = r; clr1 = c;
    @(posedge clk); #2;
    write1 = 1'b0; read1 = 1'b0; clr1 = 1'b0;
  endtask

  // Standard mode: data of a read accepted this cycle appears after the next edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend0 <= 1'b0;
    end else begin
      if (pend0) begin
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd0_unexpected: got %0d expected no read", rdata0);
        end else begin
          chk("rd0_data", 32'(rdata0), 32'(q0.pop_front()));
        end
      end
      pend0 <= read0 && !empty0 && !clr0;
    end
  end

  // FWFT mode: the displayed word is the one being acknowledged.
  always @(negedge clk) begin
    if (rst_n && read1 && !empty1 && !clr1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd1_unexpected: got %0d expected no read", rdata1);
      end else begin
        chk("rd1_data", 32'(rdata1), 32'(q1.pop_front()));
      end
    end
  end

  initial begin
    logic [7:0] exp41 [8];
    exp41 = '{8'd17, 8'd20, 8'd32, 8'd33, 8'd34, 8'd35, 8'd36, 8'd37};

    #1 rst_n = 1'b0;
    #11;
    st0("rst", 0, 1'b0, 1'b0);
    chk("rst rdata0", 32'(rdata0), 32'd0);
    st1("rst", 0, 1'b0, 1'b0);
    #5 rst_n = 1'b1;
    @(posedge clk); #2;

    for (int i = 0; i < 10; i++) begin
      logic [7:0] wd;
      wd = (i == 0) ? 8'd17 : (i == 1) ? 8'd20 : 8'(800 + i - 2);
      cyc0(1'b1, wd, 1'b0, 1'b0);
      st0($sformatf("fill%0d", i + 1), (i + 1 > 8) ? 8 : i + 1, i >= 8, 1'b0);
    end

    for (int j = 1; j <= 14; j++) begin
      if (j <= 8) q0.push_back(exp41[j-1]);
      cyc0(1'b0, 8'd0, 1'b1, 1'b0);
      st0($sformatf("drain%0d", j), (j > 8) ? 0 : 8 - j, 1'b0, j >= 9);
    end
    chk("rdata0 hold", 32'(rdata0), 32'd37);
    cyc0(1'b0, 8'd0, 1'b0, 1'b0);
    st0("idle", 0, 1'b0, 1'b0);

    for (int k = 0; k < 4; k++) begin
      cyc0(1'b1, 8'(100 + k), 1'b0, 1'b0);
      st0($sformatf("c4w%0d", k), k + 1, 1'b0, 1'b0);
    end
    for (int k = 0; k < 3; k++) begin
      q0.push_back(8'(100 + k));
      cyc0(1'b1, 8'(104 + k), 1'b1, 1'b0);
      st0($sformatf("wr_rd%0d", k), 4, 1'b0, 1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      cyc0(1'b1, 8'(107 + k), 1'b0, 1'b0);
      st0($sformatf("c8w%0d", k), 5 + k, 1'b0, 1'b0);
    end
    q0.push_back(8'd103);
    cyc0(1'b1, 8'd111, 1'b1, 1'b0);
    st0("full_wr_rd", 7, 1'b1, 1'b0);
    for (int k = 0; k < 7; k++) begin
      q0.push_back(8'(104 + k));
      cyc0(1'b0, 8'd0, 1'b1, 1'b0);
      st0($sformatf("c8r%0d", k), 6 - k, 1'b0, 1'b0);
    end

    for (int k = 1; k <= 20; k++) begin
      cyc0(1'b1, 8'(k), 1'b0, 1'b0);
      st0($sformatf("pair_w%0d", k), 1, 1'b0, 1'b0);
      q0.push_back(8'(k));
      cyc0(1'b0, 8'd0, 1'b1, 1'b0);
      st0($sformatf("pair_r%0d", k), 0, 1'b0, 1'b0);
    end

    for (int k = 0; k < 5; k++) begin
      cyc0(1'b1, 8'(200 + k), 1'b0, 1'b0);
      st0($sformatf("c5w%0d", k), k + 1, 1'b0, 1'b0);
    end
    cyc0(1'b1, 8'd99, 1'b0, 1'b1);
    st0("clr", 0, 1'b0, 1'b0);
    chk("clr rdata0", 32'(rdata0), 32'd0);
    cyc0(1'b1, 8'd7, 1'b0, 1'b0);
    st0("postclr_w", 1, 1'b0, 1'b0);
    q0.push_back(8'd7);
    cyc0(1'b0, 8'd0, 1'b1, 1'b0);
    st0("postclr_r", 0, 1'b0, 1'b0);

    for (int k = 0; k < 3; k++) begin
      cyc0(1'b1, 8'(50 + k), 1'b0, 1'b0);
      st0($sformatf("c3w%0d", k), k + 1, 1'b0, 1'b0);
    end
    #1 rst_n = 1'b0;
    #1;
    st0("arst", 0, 1'b0, 1'b0);
    chk("arst rdata0", 32'(rdata0), 32'd0);
    write0 = 1'b1; wdata0 = 8'h77;
    @(posedge clk); #2;
    chk("arst hold count0", 32'(count0), 32'd0);
    chk("arst hold empty0", 32'(empty0), 32'd1);
    write0 = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge clk); #2;
    cyc0(1'b1, 8'd60, 1'b0, 1'b0);
    st0("postrst_w", 1, 1'b0, 1'b0);
    q0.push_back(8'd60);
    cyc0(1'b0, 8'd0, 1'b1, 1'b0);
    st0("postrst_r", 0, 1'b0, 1'b0);

    cyc1(1'b1, 8'd1, 1'b0, 1'b0);
    st1("fw_w1", 1, 1'b0, 1'b0);
    chk("fw rdata1 first", 32'(rdata1), 32'd1);
    cyc1(1'b1, 8'd2, 1'b0, 1'b0);
    st1("fw_w2", 2, 1'b0, 1'b0);
    chk("fw rdata1 held", 32'(rdata1), 32'd1);
    q1.push_back(8'd1);
    cyc1(1'b0, 8'd0, 1'b1, 1'b0);
    st1("fw_r1", 1, 1'b0, 1'b0);
    chk("fw rdata1 next", 32'(rdata1), 32'd2);
    q1.push_back(8'd2);
    cyc1(1'b0, 8'd0, 1'b1, 1'b0);
    st1("fw_r2", 0, 1'b0, 1'b0);
    cyc1(1'b0, 8'd0, 1'b1, 1'b0);
    st1("fw_under", 0, 1'b0, 1'b1);
    cyc1(1'b0, 8'd0, 1'b0, 1'b0);
    st1("fw_idle", 0, 1'b0, 1'b0);

    for (int k = 1; k <= 12; k++) begin
      cyc1(1'b1, 8'(70 + k), 1'b0, 1'b0);
      st1($sformatf("fw_pw%0d", k), 1, 1'b0, 1'b0);
      chk($sformatf("fw_pw%0d rdata1", k), 32'(rdata1), 32'(70 + k));
      q1.push_back(8'(70 + k));
      cyc1(1'b0, 8'd0, 1'b1, 1'b0);
      st1($sformatf("fw_pr%0d", k), 0, 1'b0, 1'b0);
    end

    cyc1(1'b1, 8'd90, 1'b0, 1'b0);
    st1("fw_s_w", 1, 1'b0, 1'b0);
    q1.push_back(8'd90);
    cyc1(1'b1, 8'd91, 1'b1, 1'b0);
    st1("fw_s_wr", 1, 1'b0, 1'b0);
    chk("fw_s_wr rdata1", 32'(rdata1), 32'd91);
    q1.push_back(8'd91);
    cyc1(1'b0, 8'd0, 1'b1, 1'b0);
    st1("fw_s_r", 0, 1'b0, 1'b0);

    for (int k = 0; k < 8; k++) begin
      cyc1(1'b1, 8'(10 + k), 1'b0, 1'b0);
      st1($sformatf("fw_f%0d", k), k + 1, 1'b0, 1'b0);
    end
    cyc1(1'b1, 8'd18, 1'b0, 1'b0);
    st1("fw_over", 8, 1'b1, 1'b0);
    cyc1(1'b1, 8'd19, 1'b1, 1'b1);
    st1("fw_clr", 0, 1'b0, 1'b0);
    cyc1(1'b1, 8'd5, 1'b0, 1'b0);
    st1("fw_postclr", 1, 1'b0, 1'b0);
    chk("fw_postclr rdata1", 32'(rdata1), 32'd5);
    q1.push_back(8'd5);
    cyc1(1'b0, 8'd0, 1'b1, 1'b0);
    st1("fw_postclr_r", 0, 1'b0, 1'b0);

    cyc0(1'b0, 8'd0, 1'b0, 1'b0);
    cyc0(1'b0, 8'd0, 1'b0, 1'b0);
    chk("q0 drained", 32'(q0.size()), 32'd0);
    chk("q1 drained", 32'(q1.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
